// File: rtl/video_onchip_frame_reader_pkg.sv
// Shared types and default sizes for the on-chip frame reader and its output FIFO.
package video_onchip_frame_reader_pkg;

  localparam int unsigned ADDR_W_DEF     = 12;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned NUM_WORDS_DEF  = 3125;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } rd_state_e;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [DATA_W_DEF-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/video_reader_fifo.sv
// Show-ahead FIFO: the head entry is visible on rdata_o whenever empty_o is low.
module video_reader_fifo
  import video_onchip_frame_reader_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W_DEF + 2,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is accepted only when the same cycle frees a slot.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/video_onchip_frame_reader.sv
// Sequentially reads the whole frame memory and streams it as one sop/eop packet per frame.
module video_onchip_frame_reader
  import video_onchip_frame_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned NUM_WORDS  = NUM_WORDS_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } entry_t;

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              inflight_q;
  logic              tag_sop_q, tag_eop_q;

  logic              issue, pop;
  logic [CW:0]       credit_need;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  entry_t            fifo_wdata, fifo_rdata;

  assign pop = ~fifo_empty & st_ready;

  // Slots needed if we issue now: post-pop occupancy + read still in flight + this read.
  assign credit_need = {1'b0, fifo_count} - (CW+1)'(pop) + (CW+1)'(inflight_q) + (CW+1)'(1);
  assign issue       = (state_q == ST_FETCH) && (credit_need <= (CW+1)'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (issue) begin
          if (cnt_q == LAST_ADDR) begin
            cnt_d = '0;
            if (!enable) state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && fifo_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      tag_sop_q  <= 1'b0;
      tag_eop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= issue;
      tag_sop_q  <= issue && (cnt_q == '0);
      tag_eop_q  <= issue && (cnt_q == LAST_ADDR);
    end
  end

  assign fifo_wdata = '{sop: tag_sop_q, eop: tag_eop_q, data: mem_readdata};

  video_reader_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (inflight_q),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  no_overflow_a : assert property (@(posedge clk) disable iff (reset)
    !(inflight_q && fifo_full && !pop));

  assign mem_address    = cnt_q;
  assign mem_chipselect = issue;
  assign mem_clken      = 1'b1;
  assign st_valid       = ~fifo_empty;
  assign st_data        = fifo_rdata.data;
  assign st_sop         = fifo_rdata.sop;
  assign st_eop         = fifo_rdata.eop;
  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = pop & fifo_rdata.eop;

endmodule

// File: tb/tb_video_onchip_frame_reader.sv
// Self-checking bench: memory model, sequence/availability model and directed + random scenarios.
module tb_video_onchip_frame_reader;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 3125;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          reset, enable, st_ready;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect, mem_clken;
  logic [DW-1:0] mem_readdata = '0;
  logic [DW-1:0] st_data;
  logic          st_valid, st_sop, st_eop, busy, frame_done;

  always #5 clk = ~clk;

  video_onchip_frame_reader #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .NUM_WORDS  (NW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_sop         (st_sop),
    .st_eop         (st_eop),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  // Frame memory preloaded with data = address, one-cycle registered read.
  logic [DW-1:0] mem [NW];
  initial for (int i = 0; i < int'(NW); i++) mem[i] = DW'(i);

  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= (int'(mem_address) < int'(NW)) ? mem[mem_address] : '0;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: words leave in address order, a read issued in cycle N is
  // available from cycle N+2, and reads outstanding never exceed the FIFO depth.
  int unsigned   exp_xfer = 0, exp_issue = 0;
  int unsigned   n_iss = 0, n_iss_lag = 0, n_xfer = 0, frames = 0, cyc = 0;
  int unsigned   last_sop_cyc = 0, prev_sop_cyc = 0, last_eop_cyc = 0, prev_eop_cyc = 0;
  logic          hold_v = 1'b0, hold_sop, hold_eop;
  logic [DW-1:0] hold_d;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_xfer = 0; exp_issue = 0; n_iss = 0; n_iss_lag = 0; n_xfer = 0; hold_v = 1'b0;
    end else begin
      chk("st_valid_vs_model", st_valid, (n_iss_lag > n_xfer) ? 1 : 0);
      chk("outstanding_le_depth", ((n_iss - n_xfer) <= FD) ? 1 : 0, 1);
      n_iss_lag = n_iss;
      if (hold_v) begin
        chk("stall_hold_valid", st_valid, 1);
        chk("stall_hold_data", st_data, hold_d);
        chk("stall_hold_sop", st_sop, hold_sop);
        chk("stall_hold_eop", st_eop, hold_eop);
      end
      if (mem_chipselect) begin
        chk("read_address", mem_address, exp_issue);
        exp_issue = (exp_issue == NW - 1) ? 0 : exp_issue + 1;
        n_iss++;
      end
      if (st_valid && st_ready) begin
        chk("xfer_data", st_data, mem[exp_xfer]);
        chk("xfer_sop", st_sop, (exp_xfer == 0) ? 1 : 0);
        chk("xfer_eop", st_eop, (exp_xfer == NW - 1) ? 1 : 0);
        chk("frame_done_on_xfer", frame_done, (exp_xfer == NW - 1) ? 1 : 0);
        if (exp_xfer == 0) begin prev_sop_cyc = last_sop_cyc; last_sop_cyc = cyc; end
        if (exp_xfer == NW - 1) begin
          prev_eop_cyc = last_eop_cyc; last_eop_cyc = cyc; frames++;
        end
        exp_xfer = (exp_xfer == NW - 1) ? 0 : exp_xfer + 1;
        n_xfer++;
      end else begin
        chk("frame_done_no_xfer", frame_done, 0);
      end
      hold_v   = st_valid && !st_ready;
      hold_d   = st_data;
      hold_sop = st_sop;
      hold_eop = st_eop;
    end
  end

  task automatic wait_frames(input int unsigned target, input int limit, input string nm);
    int k = 0;
    while (frames < target && k < limit) begin @(posedge clk); k++; end
    chk(nm, (frames >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input int limit, input string nm);
    int k = 0;
    do begin @(posedge clk); #1; k++; end while ((busy || st_valid) && k < limit);
    chk(nm, (!busy && !st_valid) ? 1 : 0, 1);
  endtask

  task automatic wait_xfer_idx(input int unsigned idx, input int limit, input string nm);
    int k = 0;
    while (exp_xfer < idx && k < limit) begin @(posedge clk); #1; k++; end
    chk(nm, (exp_xfer >= idx) ? 1 : 0, 1);
  endtask

  initial begin
    #5_000_000;
    errors++;
    checks++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int unsigned base, iss0, stall_at;
    int          k;

    reset = 1'b1; enable = 1'b0; st_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_address", mem_address, 0);
    chk("rst_chipselect", mem_chipselect, 0);
    chk("rst_clken", mem_clken, 1);
    chk("rst_st_valid", st_valid, 0);
    chk("rst_st_sop", st_sop, 0);
    chk("rst_st_eop", st_eop, 0);
    chk("rst_st_data", st_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_read", mem_chipselect, 0);

    // Full-speed single frame with latency pinned by hand.
    enable = 1'b1; st_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("lat_c1_chipselect", mem_chipselect, 1);
    chk("lat_c1_valid", st_valid, 0);
    chk("lat_c1_busy", busy, 1);
    @(posedge clk); @(negedge clk);
    chk("lat_c2_valid", st_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("lat_c3_valid", st_valid, 1);
    chk("first_data", st_data, 0);
    chk("first_sop", st_sop, 1);
    @(posedge clk); #1 enable = 1'b0;
    wait_frames(1, 4000, "fullspeed_frame_done");
    wait_idle(100, "fullspeed_idle");
    chk("fullspeed_frames", frames, 1);
    chk("fullspeed_span", last_eop_cyc - last_sop_cyc, NW - 1);

    // Random backpressure, ~30% ready duty.
    base = frames;
    enable = 1'b1;
    k = 0;
    while (frames < base + 1 && k < 30000) begin
      @(posedge clk); #1;
      st_ready = ($urandom_range(99) < 30);
      if (k == 50) enable = 1'b0;
      k++;
    end
    chk("bp_frame_done", frames, base + 1);
    st_ready = 1'b1;
    wait_idle(100, "bp_idle");

    // 20-cycle stall mid-frame at a random word.
    base = frames;
    stall_at = $urandom_range(2000, 1000);
    enable = 1'b1;
    wait_xfer_idx(stall_at, 4000, "stall_reach");
    st_ready = 1'b0;
    iss0 = n_iss;
    repeat (20) @(posedge clk);
    #1;
    chk("stall_reads_issued", n_iss - iss0, 2);
    chk("stall_chipselect_off", mem_chipselect, 0);
    st_ready = 1'b1;
    enable = 1'b0;
    wait_frames(base + 1, 4000, "stall_frame_done");
    wait_idle(100, "stall_idle");

    // Continuous mode: two back-to-back frames.
    base = frames;
    enable = 1'b1;
    wait_frames(base + 1, 4000, "cont_frame1");
    @(posedge clk); #1 enable = 1'b0;
    wait_frames(base + 2, 4000, "cont_frame2");
    wait_idle(100, "cont_idle");
    chk("cont_two_frame_span", last_eop_cyc - prev_sop_cyc, 2 * NW - 1);
    chk("cont_no_gap", last_sop_cyc - prev_eop_cyc, 1);
    iss0 = n_iss;
    repeat (40) @(posedge clk);
    #1;
    chk("cont_no_third_frame", frames, base + 2);
    chk("cont_no_more_reads", n_iss - iss0, 0);

    // Early disable at word 100.
    base = frames;
    enable = 1'b1;
    wait_xfer_idx(100, 1000, "early_reach");
    enable = 1'b0;
    wait_frames(base + 1, 4000, "early_frame_done");
    wait_idle(100, "early_idle");
    iss0 = n_iss;
    repeat (50) @(posedge clk);
    #1;
    chk("early_no_more_reads", n_iss - iss0, 0);
    chk("early_frames", frames, base + 1);

    // Reset mid-frame at word 500.
    enable = 1'b1;
    wait_xfer_idx(500, 1500, "rstmid_reach");
    reset = 1'b1;
    #1;
    chk("rstmid_valid", st_valid, 0);
    chk("rstmid_chipselect", mem_chipselect, 0);
    chk("rstmid_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    base = frames;
    k = 0;
    do begin @(negedge clk); k++; end while (!st_valid && k < 20);
    chk("rstmid_restart_valid", st_valid, 1);
    chk("rstmid_restart_data", st_data, 0);
    chk("rstmid_restart_sop", st_sop, 1);
    @(posedge clk); #1 enable = 1'b0;
    wait_frames(base + 1, 4000, "rstmid_frame_done");
    wait_idle(100, "rstmid_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
